// File: rtl/recv_img_pkg.sv
// Shared state encodings and constants for the recv_img UART image loader.
package recv_img_pkg;

   typedef enum logic [1:0] {
      INACTIVE  = 2'd0,
      RECEIVING = 2'd1,
      DONE      = 2'd2
   } top_state_e;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_e;

   localparam logic [1:0] TIMEOUT_STATE_CODE = 2'b11;

endpackage

// File: rtl/recv_img_uart_rx.sv
// 8N1 UART receiver, LSB first: 2-flop synchroniser, start-bit glitch reject, stop-bit check.
// valid_o/err_o are one-cycle pulses the cycle after the stop-bit centre; no backpressure.
module uart_rx
   import recv_img_pkg::*;
#(
   parameter int CLOCKS_PER_BAUD = 50
) (
   input  logic       clk,
   input  logic       rst_n_in,
   input  logic       rx_in,
   output logic [7:0] data_o,
   output logic       valid_o,
   output logic       err_o
);

   localparam int            CW       = $clog2(CLOCKS_PER_BAUD);
   localparam logic [CW-1:0] FULL_CNT = CW'(CLOCKS_PER_BAUD - 1);
   localparam logic [CW-1:0] HALF_CNT = CW'(CLOCKS_PER_BAUD / 2 - 1);

   logic            meta_q, sync_q, prev_q;
   rx_state_e       state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic            valid_q, valid_d;
   logic            err_q, err_d;

   // Line idles high, so the synchroniser resets high to avoid a false start edge.
   always_ff @(posedge clk or negedge rst_n_in) begin
      if (!rst_n_in) begin
         meta_q  <= 1'b1;
         sync_q  <= 1'b1;
         prev_q  <= 1'b1;
         state_q <= RX_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         meta_q  <= rx_in;
         sync_q  <= meta_q;
         prev_q  <= sync_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         RX_IDLE: begin
            cnt_d = '0;
            if (prev_q && !sync_q) begin
               state_d = RX_START;
            end
         end
         RX_START: begin
            if (cnt_q == HALF_CNT) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = sync_q ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (cnt_q == FULL_CNT) begin
               cnt_d   = '0;
               shift_d = {sync_q, shift_q[7:1]};
               if (bit_q == 3'd7) begin
                  state_d = RX_STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
         RX_STOP: begin
            if (cnt_q == FULL_CNT) begin
               cnt_d   = '0;
               valid_d = sync_q;
               err_d   = !sync_q;
               state_d = RX_IDLE;
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

   assign data_o  = shift_q;
   assign valid_o = valid_q;
   assign err_o   = err_q;

endmodule

// File: rtl/recv_img.sv
// UART-to-BRAM image loader: stores BRAM_LENGTH bytes from address 0, we one cycle after each byte, then pulses img_received.
// No backpressure (the UART cannot stall). Define RECV_IMG_TIMEOUT_EN to restart a capture stalled for TIMEOUT_CYCLES.
module recv_img
   import recv_img_pkg::*;
#(
   parameter int BRAM_LENGTH     = 64 * 64,
   parameter int ADDR_WIDTH      = 14,
   parameter int CLOCKS_PER_BAUD = 50,
   parameter int TIMEOUT_CYCLES  = 50 * 10 * 4
) (
   input  logic                  clk,
   input  logic                  rst_n_in,
   input  logic                  rx,
   input  logic                  img_request,
   output logic [ADDR_WIDTH-1:0] address,
   output logic [7:0]            data_out,
   output logic                  we,
   output logic                  busy,
   output logic                  img_received,
   output logic                  frame_err,
   output logic [1:0]            out_state
);

   localparam logic [ADDR_WIDTH:0] LAST_PIX = (ADDR_WIDTH + 1)'(BRAM_LENGTH - 1);

   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_err;

   uart_rx #(
      .CLOCKS_PER_BAUD(CLOCKS_PER_BAUD)
   ) u_rx (
      .clk     (clk),
      .rst_n_in(rst_n_in),
      .rx_in   (rx),
      .data_o  (rx_data),
      .valid_o (rx_valid),
      .err_o   (rx_err)
   );

   top_state_e            state_q, state_d;
   logic [ADDR_WIDTH:0]   pix_count_q, pix_count_d;
   logic [ADDR_WIDTH-1:0] address_q, address_d;
   logic [7:0]            data_q, data_d;
   logic                  we_q, we_d;
   logic                  busy_q, busy_d;
   logic                  img_received_q, img_received_d;
   logic                  frame_err_q, frame_err_d;

`ifdef RECV_IMG_TIMEOUT_EN
   localparam int            GW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT_CYCLES - 1);

   logic [GW-1:0] gap_q, gap_d;
   logic          timeout_q, timeout_d;

   always_ff @(posedge clk or negedge rst_n_in) begin
      if (!rst_n_in) begin
         gap_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         gap_q     <= gap_d;
         timeout_q <= timeout_d;
      end
   end
`else
   // Timeout support compiled out; parameter kept for a uniform interface.
   localparam int timeout_cycles_unused = TIMEOUT_CYCLES;
`endif

   always_ff @(posedge clk or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q        <= INACTIVE;
         pix_count_q    <= '0;
         address_q      <= '0;
         data_q         <= '0;
         we_q           <= 1'b0;
         busy_q         <= 1'b0;
         img_received_q <= 1'b0;
         frame_err_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         pix_count_q    <= pix_count_d;
         address_q      <= address_d;
         data_q         <= data_d;
         we_q           <= we_d;
         busy_q         <= busy_d;
         img_received_q <= img_received_d;
         frame_err_q    <= frame_err_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      pix_count_d    = pix_count_q;
      address_d      = address_q;
      data_d         = data_q;
      we_d           = 1'b0;
      busy_d         = busy_q;
      img_received_d = 1'b0;
      frame_err_d    = frame_err_q;
`ifdef RECV_IMG_TIMEOUT_EN
      gap_d          = '0;
      timeout_d      = 1'b0;
`endif
      case (state_q)
         INACTIVE: begin
            busy_d = 1'b0;
            if (img_request) begin
               state_d     = RECEIVING;
               pix_count_d = '0;
               frame_err_d = 1'b0;
               busy_d      = 1'b1;
            end
         end
         RECEIVING: begin
            if (rx_valid) begin
               we_d        = 1'b1;
               data_d      = rx_data;
               address_d   = pix_count_q[ADDR_WIDTH-1:0];
               pix_count_d = pix_count_q + 1'b1;
               if (pix_count_q == LAST_PIX) begin
                  state_d = DONE;
               end
            end else if (rx_err) begin
               frame_err_d = 1'b1;
            end
`ifdef RECV_IMG_TIMEOUT_EN
            // Only a started image can stall; an empty capture waits forever.
            if (!rx_valid && pix_count_q != '0) begin
               if (gap_q == GAP_LAST) begin
                  pix_count_d = '0;
                  timeout_d   = 1'b1;
               end else begin
                  gap_d = gap_q + 1'b1;
               end
            end
`endif
         end
         DONE: begin
            img_received_d = 1'b1;
            busy_d         = 1'b0;
            state_d        = INACTIVE;
         end
         default: state_d = INACTIVE;
      endcase
   end

   assign address      = address_q;
   assign data_out     = data_q;
   assign we           = we_q;
   assign busy         = busy_q;
   assign img_received = img_received_q;
   assign frame_err    = frame_err_q;

`ifdef RECV_IMG_TIMEOUT_EN
   assign out_state = timeout_q ? TIMEOUT_STATE_CODE : state_q;
`else
   assign out_state = state_q;
`endif

endmodule

// File: tb/tb_recv_img.sv
// Self-checking bench for recv_img: directed tables, reset/glitch sequences and a randomized image scoreboard.
module tb_recv_img;
   localparam int CPB = 8;
   localparam int BL  = 16;
   localparam int AW  = 4;
   localparam int TO  = 200;

   logic          clk         = 1'b0;
   logic          rst_n_in    = 1'b0;
   logic          rx          = 1'b1;
   logic          img_request = 1'b0;
   logic [AW-1:0] address;
   logic [7:0]    data_out;
   logic          we, busy, img_received, frame_err;
   logic [1:0]    out_state;

   recv_img #(
      .BRAM_LENGTH(BL), .ADDR_WIDTH(AW), .CLOCKS_PER_BAUD(CPB), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst_n_in(rst_n_in), .rx(rx), .img_request(img_request),
      .address(address), .data_out(data_out), .we(we), .busy(busy),
      .img_received(img_received), .frame_err(frame_err), .out_state(out_state)
   );

   always #5 clk = ~clk;

   int            n_checks = 0;
   int            n_fail   = 0;
   int            cyc      = 0;
   logic [AW-1:0] got_addr[$];
   logic [7:0]    got_data[$];
   int            got_cyc[$];
   int            rcv_cycles   = 0;
   int            rcv_last_cyc = 0;
   int            ts_cycles    = 0;
   logic          vld_prev     = 1'b0;

   typedef struct {
      logic [7:0]    dat;
      logic          stop_ok;
      logic          req;
      int            exp_wr;
      logic [AW-1:0] exp_addr;
      logic          exp_ferr;
   } vec_t;
   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Write log plus latency check: a byte accepted while RECEIVING must show up as we on the next cycle.
   always @(negedge clk) begin
      cyc++;
      if (we) begin
         got_addr.push_back(address);
         got_data.push_back(data_out);
         got_cyc.push_back(cyc);
      end
      if (img_received) begin
         rcv_cycles++;
         rcv_last_cyc = cyc;
      end
      if (out_state == 2'b11) ts_cycles++;
      if (vld_prev) check("we_latency", {31'd0, we}, 32'd1);
      vld_prev = dut.u_rx.valid_o && (out_state == 2'd1) && rst_n_in;
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_ok);
      rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick(CPB);
      end
      rx = stop_ok;
      tick(CPB);
      rx = 1'b1;
      tick(4);
   endtask

   task automatic arm();
      img_request = 1'b1;
      tick(1);
      img_request = 1'b0;
      tick(1);
   endtask

   task automatic do_reset();
      rst_n_in = 1'b0;
      tick(3);
      rst_n_in = 1'b1;
      tick(2);
   endtask

   task automatic clear_log();
      got_addr.delete();
      got_data.delete();
      got_cyc.delete();
      rcv_cycles = 0;
      ts_cycles  = 0;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_address"}, 32'(address), 32'd0);
      check({tag, "_data_out"}, 32'(data_out), 32'd0);
      check({tag, "_we"}, 32'(we), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_img_received"}, 32'(img_received), 32'd0);
      check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
      check({tag, "_out_state"}, 32'(out_state), 32'd0);
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] exp_q[$];
      logic       exp_ferr;
      logic [7:0] b;
      logic       ok;
      int         n0;

      vecs[0] = '{8'h11, 1'b0, 1'b0, 0, 4'd0, 1'b1};
      vecs[1] = '{8'h22, 1'b1, 1'b0, 1, 4'd0, 1'b1};
      vecs[2] = '{8'hFF, 1'b1, 1'b1, 1, 4'd1, 1'b1};
      vecs[3] = '{8'h80, 1'b0, 1'b0, 0, 4'd0, 1'b1};
      vecs[4] = '{8'h01, 1'b1, 1'b0, 1, 4'd2, 1'b1};
      vecs[5] = '{8'hC3, 1'b1, 1'b1, 1, 4'd3, 1'b1};

      // Reset state
      tick(2);
      check_outputs_zero("reset");
      rst_n_in = 1'b1;
      tick(2);

      // Full image 0x00..0x0F
      clear_log();
      arm();
      check("armed_busy", 32'(busy), 32'd1);
      check("armed_state", 32'(out_state), 32'd1);
      for (int i = 0; i < BL; i++) send_byte(8'(i), 1'b1);
      tick(4);
      check("full_wr_count", got_addr.size(), BL);
      if (got_addr.size() == BL) begin
         for (int i = 0; i < BL; i++) begin
            check("full_addr", 32'(got_addr[i]), i);
            check("full_data", 32'(got_data[i]), i);
         end
         check("rcv_after_last_we", rcv_last_cyc - got_cyc[BL-1], 1);
      end
      check("rcv_pulse_width", rcv_cycles, 1);
      check("full_busy_after", 32'(busy), 32'd0);
      check("full_state_after", 32'(out_state), 32'd0);

      // Idle discard, then a fresh capture
      clear_log();
      send_byte(8'hA5, 1'b1);
      tick(4);
      check("idle_discard_count", got_addr.size(), 0);
      arm();
      send_byte(8'h3C, 1'b1);
      send_byte(8'h44, 1'b1);
      check("idle_then_arm_count", got_addr.size(), 2);
      if (got_addr.size() == 2) begin
         check("arm_addr0", 32'(got_addr[0]), 32'd0);
         check("arm_data0", 32'(got_data[0]), 32'h3C);
         check("arm_addr1", 32'(got_addr[1]), 32'd1);
      end

      // Async reset mid-byte
      send_byte(8'h11, 1'b0);
      check("pre_reset_ferr", 32'(frame_err), 32'd1);
      clear_log();
      b = 8'h99;
      rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 3; i++) begin
         rx = b[i];
         tick(CPB);
      end
      #3 rst_n_in = 1'b0;
      #1 check_outputs_zero("async_reset");
      tick(1);
      rx = 1'b1;
      tick(CPB * 8);
      rst_n_in = 1'b1;
      tick(2);
      check("reset_no_partial_write", got_addr.size(), 0);
      arm();
      send_byte(8'h5A, 1'b1);
      check("post_reset_count", got_addr.size(), 1);
      if (got_addr.size() == 1) begin
         check("post_reset_addr", 32'(got_addr[0]), 32'd0);
         check("post_reset_data", 32'(got_data[0]), 32'h5A);
      end

      // Framing errors and ignored img_request, table driven
      do_reset();
      arm();
      clear_log();
      foreach (vecs[k]) begin
         n0 = got_addr.size();
         if (vecs[k].req) begin
            img_request = 1'b1;
            tick(1);
            img_request = 1'b0;
         end
         send_byte(vecs[k].dat, vecs[k].stop_ok);
         check("vec_wr_count", got_addr.size() - n0, vecs[k].exp_wr);
         if (vecs[k].exp_wr == 1 && got_addr.size() == n0 + 1) begin
            check("vec_addr", 32'(got_addr[n0]), 32'(vecs[k].exp_addr));
            check("vec_data", 32'(got_data[n0]), 32'(vecs[k].dat));
         end
         check("vec_frame_err", 32'(frame_err), 32'(vecs[k].exp_ferr));
      end
      for (int i = 4; i < BL; i++) send_byte(8'(i + 8'h40), 1'b1);
      tick(4);
      check("ferr_image_count", got_addr.size(), BL);
      check("ferr_image_rcv", rcv_cycles, 1);
      check("ferr_sticky_inactive", 32'(frame_err), 32'd1);
      arm();
      check("ferr_cleared_on_arm", 32'(frame_err), 32'd0);

      // Glitch reject
      clear_log();
      rx = 1'b0;
      tick(2);
      rx = 1'b1;
      tick(20);
      check("glitch_no_write", got_addr.size(), 0);
      check("glitch_no_err", 32'(frame_err), 32'd0);
      send_byte(8'h6B, 1'b1);
      check("glitch_next_count", got_addr.size(), 1);
      if (got_addr.size() == 1) begin
         check("glitch_next_addr", 32'(got_addr[0]), 32'd0);
         check("glitch_next_data", 32'(got_data[0]), 32'h6B);
      end

      // Randomized images against a queue model of accepted bytes
      do_reset();
      for (int it = 0; it < 3; it++) begin
         clear_log();
         exp_q.delete();
         exp_ferr = 1'b0;
         for (int j = $urandom_range(0, 2); j > 0; j--) send_byte(8'($urandom), 1'b1);
         arm();
         while (exp_q.size() < BL) begin
            b  = 8'($urandom);
            ok = ($urandom_range(0, 4) != 0);
            send_byte(b, ok);
            if (ok) exp_q.push_back(b);
            else    exp_ferr = 1'b1;
            tick($urandom_range(0, 15));
         end
         tick(4);
         check("rand_wr_count", got_addr.size(), BL);
         if (got_addr.size() == BL) begin
            for (int i = 0; i < BL; i++) begin
               check("rand_addr", 32'(got_addr[i]), i);
               check("rand_data", 32'(got_data[i]), 32'(exp_q[i]));
            end
         end
         check("rand_frame_err", 32'(frame_err), 32'(exp_ferr));
         check("rand_rcv", rcv_cycles, 1);
         check("rand_busy", 32'(busy), 32'd0);
      end

`ifdef RECV_IMG_TIMEOUT_EN
      // Stalled capture restarts at address 0
      arm();
      clear_log();
      for (int i = 0; i < 3; i++) send_byte(8'(8'h70 + i), 1'b1);
      ts_cycles = 0;
      tick(TO + 60);
      check("timeout_state_pulse", ts_cycles, 1);
      check("timeout_busy", 32'(busy), 32'd1);
      send_byte(8'h77, 1'b1);
      check("timeout_count", got_addr.size(), 4);
      if (got_addr.size() == 4) begin
         check("timeout_addr", 32'(got_addr[3]), 32'd0);
         check("timeout_data", 32'(got_data[3]), 32'h77);
      end
`else
      check("no_timeout_state", ts_cycles, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/recv_img.md
Name: recv_img

Overview:
- UART-to-BRAM image loader; the receive-side counterpart of the image transmit path.
- Once armed, it deserialises bytes arriving on uart_rxd (8N1, LSB first) and writes each byte into the image BRAM at consecutive addresses from 0.
- It raises a one-cycle done pulse when BRAM_LENGTH pixels are stored, which then feeds the downstream image_ready/send logic.

Parameters:
- BRAM_LENGTH, 64*64, pixels per image; must be in 1..2**ADDR_WIDTH.
- ADDR_WIDTH, 14, width of the BRAM address port.
- CLOCKS_PER_BAUD, 50, clk cycles per UART bit; must be at least 4.
- TIMEOUT_CYCLES, 50*10*4, idle-gap limit in cycles; used only when RECV_IMG_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n_in  in  1  asynchronous, active-low reset.
- rx  in  1  uart_rxd; asynchronous to clk, idles high.
- img_request  in  1  level; arms a new capture when sampled high in INACTIVE.
- address  out  ADDR_WIDTH  BRAM write address.
- data_out  out  8  BRAM write data.
- we  out  1  BRAM write enable; one-cycle pulse per stored pixel.
- busy  out  1  high while a capture is in progress.
- img_received  out  1  one-cycle pulse when the full image is stored.
- frame_err  out  1  sticky; set by any stop-bit error during a capture.
- out_state  out  2  debug encoding of the current state.

Behaviour:
- Reset:
  - Asserting rst_n_in low immediately forces every output to 0, the FSM to INACTIVE, pix_count to 0 and the UART receiver to idle.
  - Assertion is effective mid-byte and mid-image; no partial write is issued.
  - Release is synchronous to clk.
- rx front end: two-flop synchroniser; all later logic uses only the synchronised signal.
- UART receiver FSM (RX_IDLE, RX_START, RX_DATA, RX_STOP):
  - RX_IDLE: a high-to-low transition on synchronised rx enters RX_START.
  - RX_START: sample at CLOCKS_PER_BAUD/2. If rx is high, treat it as a glitch and return to RX_IDLE with no output.
  - RX_DATA: sample 8 bits, one every CLOCKS_PER_BAUD cycles, shifted LSB first.
  - RX_STOP: sample the stop bit at the next bit centre.
    - Stop bit high: valid pulse for 1 cycle with the byte.
    - Stop bit low: err pulse for 1 cycle, no valid.
  - After either case, return to RX_IDLE. A new falling edge is accepted only after rx has been seen high.
- Top FSM, out_state encoding INACTIVE=0, RECEIVING=1, DONE=2:
  - INACTIVE: busy=0. If img_request is high: go to RECEIVING, pix_count<=0, frame_err<=0, busy<=1. Bytes arriving in INACTIVE are discarded.
  - RECEIVING, on valid: we<=1, data_out<=byte, address<=pix_count, pix_count<=pix_count+1.
    - If pix_count==BRAM_LENGTH-1, go to DONE.
    - Latency is 1 cycle from valid to we high.
    - we is 0 on every other cycle; data_out and address hold their last values.
  - RECEIVING, on err: the byte is dropped, frame_err<=1 and pix_count is unchanged.
  - DONE: img_received<=1 for exactly one cycle, busy<=0, then INACTIVE.
  - img_request held high re-arms on the cycle after the return to INACTIVE.
- Arithmetic: pix_count is ADDR_WIDTH+1 bits so it never wraps. The address never exceeds BRAM_LENGTH-1.
- Simultaneous events:
  - valid and err are mutually exclusive by construction.
  - img_request is ignored outside INACTIVE.

Optional Feature:
- Macro: RECV_IMG_TIMEOUT_EN.
- Defined: in RECEIVING with pix_count>0, a gap counter counts cycles with no valid and clears on every valid. When it reaches TIMEOUT_CYCLES:
  - pix_count<=0 so the capture restarts at address 0;
  - out_state shows 2'b11 for one cycle;
  - busy stays 1.
- Undefined: no gap counter; the module waits indefinitely for the remaining bytes.

Decomposition:
- recv_img_pkg holds:
  - the top-state enum {INACTIVE, RECEIVING, DONE} with explicit 2-bit values;
  - the rx-state enum;
  - the constant TIMEOUT_STATE_CODE=2'b11.
- Sub-module uart_rx owns the synchroniser and bit FSM.
  - Ports: clk, rst_n_in, rx_in, data_o[7:0], valid_o, err_o.
  - It is parameterised by CLOCKS_PER_BAUD.

Test Plan (sim: CLOCKS_PER_BAUD=8, BRAM_LENGTH=16):
- Async reset mid-byte: drop rst_n_in low between edges during RX_DATA -> all outputs 0 before the next clk edge; after release a fresh byte 0x5A lands at address 0.
- Full image: pulse img_request, send bytes 0x00..0x0F -> 16 we pulses, address 0..15 with data equal to address, 1 cycle after each valid. img_received is high for exactly 1 cycle after the 16th write, then busy=0 and out_state=0.
- Idle discard: send 0xA5 while INACTIVE -> no we pulse. Then arm and send 0x3C -> write to address 0 with 0x3C.
- Framing error: in RECEIVING send 0x11 with stop bit low, then 0x22 -> frame_err=1, a single write of 0x22 at address 0. frame_err clears on the next arm.
- Glitch reject: a 2-cycle low pulse on rx -> no valid and no err; the receiver returns to idle and the next byte is received correctly.
- With RECV_IMG_TIMEOUT_EN and TIMEOUT_CYCLES=200: send 3 bytes, then idle 200 cycles -> out_state=3 for 1 cycle. The next byte is written at address 0.
